// File: rtl/nn_pkg.sv
// Shared types and constants for the network weight/input loader.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    DONE   = 2'd3
  } nn_state_e;

  localparam logic CMD_WEIGHTS = 1'b0;
  localparam logic CMD_INPUTS  = 1'b1;

endpackage

// File: rtl/nn_addr_counter.sv
// Node/layer write-address counter; node wraps per layer, layer advances only in weight loads.
module nn_addr_counter #(
  parameter int unsigned LAYER_SIZE  = 3,
  parameter int unsigned LAYER_DEPTH = 2,
  localparam int unsigned AW_L = $clog2(LAYER_DEPTH),
  localparam int unsigned AW_N = $clog2(LAYER_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            wrap_layer,
  output logic [AW_N-1:0] node,
  output logic [AW_L-1:0] layer,
  output logic            last
);

  logic node_max;
  logic layer_max;

  assign node_max  = (node == AW_N'(LAYER_SIZE - 1));
  assign layer_max = (layer == AW_L'(LAYER_DEPTH - 1));
  // Input loads fill a single layer, so the last node alone ends them.
  assign last      = node_max && (layer_max || !wrap_layer);

  // Counter update: clear on command, advance on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      node  <= '0;
      layer <= '0;
    end else if (step) begin
      if (node_max) begin
        node <= '0;
        if (wrap_layer) begin
          layer <= layer + AW_L'(1);
        end
      end else begin
        node <= node + AW_N'(1);
      end
    end
  end

endmodule

// File: rtl/nn_loader.sv
// Streams weight or input words into the network memories, one write per accepted beat.
module nn_loader
  import nn_pkg::*;
#(
  parameter int unsigned LAYER_SIZE  = 3,
  parameter int unsigned LAYER_DEPTH = 2,
  parameter int unsigned BIT_SIZE    = 8,
  localparam int unsigned AW_L = $clog2(LAYER_DEPTH),
  localparam int unsigned AW_N = $clog2(LAYER_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_type,
  output logic                cmd_ready,
  input  logic                abort,
  input  logic                s_valid,
  input  logic [BIT_SIZE-1:0] s_data,
  output logic                s_ready,
  output logic                weight_write_enable,
  output logic                input_write_enable,
  output logic [AW_L-1:0]     addr_layer,
  output logic [AW_N-1:0]     addr_node,
  output logic [BIT_SIZE-1:0] data_out,
  output logic                input_select,
  output logic                busy,
  output logic                done
);

  nn_state_e       state;
  nn_state_e       state_nxt;
  logic            is_load;
  logic            handshake;
  logic            accept;
  logic            load_inputs;
  logic [AW_N-1:0] cnt_node;
  logic [AW_L-1:0] cnt_layer;
  logic            cnt_last;

  assign is_load   = (state == LOAD_W) || (state == LOAD_X);
  assign cmd_ready = (state == IDLE) && !rst;
  assign s_ready   = is_load && !abort && !rst;
  assign handshake = cmd_valid && cmd_ready;
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  nn_addr_counter #(
    .LAYER_SIZE  (LAYER_SIZE),
    .LAYER_DEPTH (LAYER_DEPTH)
  ) u_addr_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (handshake),
    .step       (accept),
    .wrap_layer (state == LOAD_W),
    .node       (cnt_node),
    .layer      (cnt_layer),
    .last       (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort wins over a final beat since no beat is accepted under abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = (cmd_type == CMD_INPUTS) ? LOAD_X : LOAD_W;
        end
      end
      LOAD_W, LOAD_X: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (accept && cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write port: strobe, address and data follow the accepted beat by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_write_enable <= 1'b0;
      input_write_enable  <= 1'b0;
      addr_layer          <= '0;
      addr_node           <= '0;
      data_out            <= '0;
    end else begin
      weight_write_enable <= accept && (state == LOAD_W);
      input_write_enable  <= accept && (state == LOAD_X);
      if (accept) begin
        addr_layer <= cnt_layer;
        addr_node  <= cnt_node;
        data_out   <= s_data;
      end
    end
  end

  // Load-mode memory and input_select: cleared when an input load starts, set once it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_inputs  <= 1'b0;
      input_select <= 1'b0;
    end else begin
      if (handshake) begin
        load_inputs <= cmd_type;
      end
      if (handshake && (cmd_type == CMD_INPUTS)) begin
        input_select <= 1'b0;
      end else if ((state == DONE) && load_inputs) begin
        input_select <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_loader.sv
// Scoreboard bench for nn_loader at LAYER_SIZE=3, LAYER_DEPTH=2, BIT_SIZE=8.
module tb_nn_loader;

  localparam int unsigned LS   = 3;
  localparam int unsigned LD   = 2;
  localparam int unsigned BW   = 8;
  localparam int unsigned AW_L = 1;
  localparam int unsigned AW_N = 2;

  typedef struct packed {
    logic            w;
    logic            i;
    logic [AW_L-1:0] layer;
    logic [AW_N-1:0] node;
    logic [BW-1:0]   data;
    logic            last;
  } wr_t;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_type;
  logic            cmd_ready;
  logic            abort;
  logic            s_valid;
  logic [BW-1:0]   s_data;
  logic            s_ready;
  logic            weight_write_enable;
  logic            input_write_enable;
  logic [AW_L-1:0] addr_layer;
  logic [AW_N-1:0] addr_node;
  logic [BW-1:0]   data_out;
  logic            input_select;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  wr_t sb[$];
  logic            m_inputs;
  int              m_node;
  int              m_layer;
  logic            exp_isel;

  nn_loader #(
    .LAYER_SIZE  (LS),
    .LAYER_DEPTH (LD),
    .BIT_SIZE    (BW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_type            (cmd_type),
    .cmd_ready           (cmd_ready),
    .abort               (abort),
    .s_valid             (s_valid),
    .s_data              (s_data),
    .s_ready             (s_ready),
    .weight_write_enable (weight_write_enable),
    .input_write_enable  (input_write_enable),
    .addr_layer          (addr_layer),
    .addr_node           (addr_node),
    .data_out            (data_out),
    .input_select        (input_select),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest expected write, including done alignment.
  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (weight_write_enable || input_write_enable) begin
      got = '{w: weight_write_enable, i: input_write_enable, layer: addr_layer,
              node: addr_node, data: data_out, last: done};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got=%h at %0t", got, $time);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write_payload got=%h exp=%h at %0t", got, exp, $time);
        end
      end
    end else if (done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_without_strobe at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic t);
    cmd_valid = 1'b1;
    cmd_type  = t;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    m_inputs  = t;
    m_node    = 0;
    m_layer   = 0;
    if (t) exp_isel = 1'b0;
    checks++;
    if ({busy, cmd_ready, input_select} !== {1'b1, 1'b0, exp_isel}) begin
      errors++;
      $display("FAIL cmd_accept got=%b%b%b exp=10%b", busy, cmd_ready, input_select, exp_isel);
    end
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input int gap);
    wr_t e;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL s_ready got=%b exp=1", s_ready);
    end
    e.w     = !m_inputs;
    e.i     = m_inputs;
    e.layer = AW_L'(m_layer);
    e.node  = AW_N'(m_node);
    e.data  = d;
    e.last  = m_inputs ? (m_node == LS - 1) : (m_node == LS - 1 && m_layer == LD - 1);
    sb.push_back(e);
    if (m_node == LS - 1) begin
      m_node = 0;
      if (!m_inputs) m_layer++;
    end else begin
      m_node++;
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if ({weight_write_enable, input_write_enable} !== {!m_inputs, m_inputs}) begin
      errors++;
      $display("FAIL strobe_latency got=%b%b exp=%b%b", weight_write_enable,
               input_write_enable, !m_inputs, m_inputs);
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      checks++;
      if ({weight_write_enable, input_write_enable} !== 2'b00) begin
        errors++;
        $display("FAIL gap_strobe got=%b%b exp=00", weight_write_enable, input_write_enable);
      end
    end
  endtask

  // Full load followed by DONE and return-to-IDLE checks.
  task automatic run_load(input logic t, input logic [BW-1:0] base, input int gap);
    int n;
    n = t ? LS : LS * LD;
    send_cmd(t);
    for (int k = 0; k < n; k++) begin
      send_beat(base + BW'(k), (k == n - 1) ? 0 : gap);
    end
    checks++;
    if ({done, busy, input_select} !== {1'b1, 1'b1, exp_isel}) begin
      errors++;
      $display("FAIL done_cycle got=%b%b%b exp=11%b", done, busy, input_select, exp_isel);
    end
    tick();
    if (t) exp_isel = 1'b1;
    checks++;
    if ({done, busy, cmd_ready, input_select} !== {1'b0, 1'b0, 1'b1, exp_isel}) begin
      errors++;
      $display("FAIL after_done got=%b%b%b%b exp=001%b", done, busy, cmd_ready,
               input_select, exp_isel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, s_ready, weight_write_enable, input_write_enable, addr_layer, addr_node,
         data_out, input_select, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b %h %h %h %b%b%b exp=all zero", cmd_ready,
               s_ready, weight_write_enable, input_write_enable, addr_layer, addr_node,
               data_out, input_select, busy, done);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_weight_load();
    run_load(1'b0, 8'h10, 0);
  endtask

  task automatic test_input_load();
    run_load(1'b1, 8'hA0, 2);
  endtask

  task automatic test_abort();
    send_cmd(1'b0);
    send_beat(8'h40, 0);
    send_beat(8'h41, 0);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h99;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_s_ready got=%b exp=0", s_ready);
    end
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    checks++;
    if ({weight_write_enable, done, busy, cmd_ready, input_select} !== {4'b0001, exp_isel}) begin
      errors++;
      $display("FAIL abort_idle got=%b%b%b%b%b exp=0001%b", weight_write_enable, done, busy,
               cmd_ready, input_select, exp_isel);
    end
    run_load(1'b0, 8'h20, 1);
    // Aborting an input load leaves input_select cleared.
    send_cmd(1'b1);
    send_beat(8'hB0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({input_write_enable, done, busy, cmd_ready, input_select} !== 5'b00010) begin
      errors++;
      $display("FAIL abort_input got=%b%b%b%b%b exp=00010", input_write_enable, done, busy,
               cmd_ready, input_select);
    end
  endtask

  task automatic test_cmd_held();
    send_cmd(1'b0);
    cmd_valid = 1'b1;
    for (int k = 0; k < LS * LD; k++) begin
      send_beat(8'h60 + BW'(k), 0);
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL held_cmd_ready beat=%0d got=%b exp=0", k, cmd_ready);
      end
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_cmd_after_done got=%b exp=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    m_inputs  = 1'b0;
    m_node    = 0;
    m_layer   = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_second_cmd got=%b exp=1", busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_abort_idle got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    send_cmd(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_beat(8'h50 + BW'(k), 0);
    end
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick();
    s_valid  = 1'b0;
    exp_isel = 1'b0;
    checks++;
    if ({cmd_ready, s_ready, weight_write_enable, input_write_enable, addr_layer, addr_node,
         data_out, input_select, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load got=%b%b%b%b %h %h %h %b%b%b exp=all zero", cmd_ready,
               s_ready, weight_write_enable, input_write_enable, addr_layer, addr_node,
               data_out, input_select, busy, done);
    end
    rst = 1'b0;
    run_load(1'b0, 8'h30, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_inputs  = 1'b0;
    m_node    = 0;
    m_layer   = 0;
    exp_isel  = 1'b0;
    test_reset();
    test_weight_load();
    test_input_load();
    test_abort();
    test_cmd_held();
    test_reset_mid_load();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
